// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one Uart8 transmitter among
// NUM_REQ byte requesters. One byte is granted per IDLE visit. txStart is held
// only until the transmitter reports busy, so a stuck start cannot retrigger.
// Optional build macro UART_ARB_TIMEOUT_EN adds a start-attempt watchdog that
// aborts a frame whose txBusy never rises within START_TIMEOUT clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 arbEn,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic [NUM_REQ-1:0]   reqDone,
  output logic [2:0]           grantIdx,
  output logic                 arbBusy,
  output logic                 errTimeout,
  output logic                 txEn,
  output logic                 txStart,
  output logic [7:0]           txIn,
  input  logic                 txBusy,
  input  logic                 txDone
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_RELEASE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         grant_q, grant_d;
  logic [7:0]         tx_in_q, tx_in_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic               err_timeout_q, err_timeout_d;
`endif

  // Requester lanes padded to 8 so a 3-bit index never leaves the array.
  logic [7:0] req_bytes [8];
  logic [7:0] valid_ext;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    if (gi < NUM_REQ) begin : g_used
      assign req_bytes[gi] = reqData[8*gi +: 8];
      assign valid_ext[gi] = reqValid[gi];
    end else begin : g_pad
      assign req_bytes[gi] = 8'h00;
      assign valid_ext[gi] = 1'b0;
    end
  end

  // Round-robin pick: first valid requester after last_q, wrapping modulo NUM_REQ.
  logic       win_found;
  logic [2:0] win_idx;
  logic [3:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    // Scan farthest-first so the nearest candidate overwrites and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (valid_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // Next-state and output computation; every output is taken from a register.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    tx_in_d     = tx_in_q;
    tx_en_d     = tx_en_q;
    tx_start_d  = tx_start_q;
    req_ready_d = '0;
    req_done_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d     = 16'd0;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tx_en_d = arbEn;
        if (arbEn && win_found) begin
          state_d     = S_START;
          tx_in_d     = req_bytes[win_idx];
          grant_d     = win_idx;
          last_d      = win_idx;
          req_ready_d = NUM_REQ'(1) << win_idx;
          tx_start_d  = 1'b1;
          tx_en_d     = 1'b1;
        end
      end
      S_START: begin
        if (txBusy) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 16'(START_TIMEOUT)) begin
          // Abandon the byte; last_q keeps the aborted index.
          tx_start_d    = 1'b0;
          err_timeout_d = 1'b1;
          tx_en_d       = arbEn;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (txDone) begin
          req_done_d = NUM_REQ'(1) << grant_q;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Wait for the transmitter to settle so the next grant sees a clean idle.
        if (!txBusy && !txDone) begin
          tx_en_d = arbEn;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the transmitter idle via txEn.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= S_IDLE;
      last_q      <= 3'(NUM_REQ - 1);
      grant_q     <= 3'd0;
      tx_in_q     <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= 16'd0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      tx_in_q     <= tx_in_d;
      tx_en_q     <= tx_en_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  assign errTimeout = err_timeout_q;
`else
  assign errTimeout = 1'b0;
`endif

  assign reqReady = req_ready_q;
  assign reqDone  = req_done_q;
  assign grantIdx = grant_q;
  assign arbBusy  = (state_q != S_IDLE);
  assign txEn     = tx_en_q;
  assign txStart  = tx_start_q;
  assign txIn     = tx_in_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one Uart8 transmitter among `NUM_REQ` byte requesters. It accepts one byte at a time from the winning requester and sequences the Uart8 `txEn`/`txStart`/`txIn` controls. It releases `txStart` once the frame has started, so that a held start cannot trigger a back-to-back retransmission. It sits between on-chip byte producers and the Uart8 tx interface; the Uart8 rx side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `START_TIMEOUT`, 4096: clocks allowed between `txStart` rising and `txBusy` being sampled high. Only used with `UART_ARB_TIMEOUT_EN`.

- `clk`  in  1  system clock, also drives Uart8.
- `rstN`  in  1  synchronous, active-low reset.
- `arbEn`  in  1  while high, new grants are allowed.
- `reqValid`  in  NUM_REQ  per-requester byte-pending flag; held until that requester's `reqReady` bit pulses.
- `reqData`  in  8*NUM_REQ  byte i is `reqData[8*i+7:8*i]`; must be stable while `reqValid[i]` is high.
- `reqReady`  out  NUM_REQ  one-cycle pulse when the byte is captured.
- `reqDone`  out  NUM_REQ  one-cycle pulse when that requester's frame completes.
- `grantIdx`  out  3  index of the current or last granted requester.
- `arbBusy`  out  1  high whenever the state is not IDLE.
- `errTimeout`  out  1  one-cycle pulse when a start attempt is aborted.
- `txEn`, `txStart`  out  1 each  drive the Uart8 controls of the same names.
- `txIn`  out  8  drives the Uart8 `txIn`.
- `txBusy`, `txDone`  in  1 each  driven by the Uart8 outputs of the same names.

## Operation
- States: IDLE, START, WAIT_DONE, RELEASE. All outputs are registered.
- **Reset** (rstN low at an edge):
  - State goes to IDLE.
  - All outputs are 0, including `txEn`; this forces Uart8 idle even mid-frame.
  - Round-robin pointer `last` = NUM_REQ-1, so requester 0 has first priority.
- **IDLE**:
  - `txEn` = `arbEn`.
  - If `arbEn` and any `reqValid` bit is high, the winner is the first set bit scanning `last+1`, `last+2`, … modulo NUM_REQ.
  - At the next edge: `txIn` <= winner's byte, `grantIdx` <= winner, `last` <= winner, `reqReady[winner]` = 1 for one cycle, `txStart` <= 1, `txEn` <= 1, go to START.
- **START**:
  - `txStart` is held high and `txIn` is held until `txBusy` is sampled 1.
  - Then, at the next edge, `txStart` <= 0 and the state goes to WAIT_DONE.
- **WAIT_DONE**:
  - `txIn` is held stable.
  - When `txDone` is sampled 1, at the next edge `reqDone[grantIdx]` = 1 for one cycle and the state goes to RELEASE.
- **RELEASE**: when `txBusy` == 0 and `txDone` == 0 are both sampled, go to IDLE. Grant decisions are made only in IDLE, so consecutive frames are separated by at least one IDLE cycle.
- **arbEn low**:
  - No new grants are made.
  - An in-flight frame completes normally.
  - `txEn` stays 1 until the state returns to IDLE, then `txEn` = 0.
- `reqValid` deasserting before grant is legal; that requester is skipped.
- `reqValid[i]` held high after its `reqReady` pulse is treated as a new byte, eligible in the next IDLE.
- Only one `reqReady` bit and one `reqDone` bit is ever high, and never in the same cycle.

## Timing
- Grant latency: `reqValid` sampled at edge n in IDLE, so `reqReady` and `txStart` are high in the cycle after edge n.
- `txStart` width: from grant until 1 cycle after the first sampled `txBusy` = 1. Uart8 starts on its baud tick, so this is up to one bit period (1250 clk at 12 MHz / 9600 baud).
- Completion: `reqDone` pulses 1 cycle after `txDone` is first sampled high.
- Frame throughput: one Uart8 frame plus 3 to 4 arbiter cycles per byte.
- Simultaneous requests: all are served in rotation order starting after `last`. No requester waits more than NUM_REQ-1 frames.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in START.
  - If it reaches `START_TIMEOUT` without `txBusy` being sampled high, then at the next edge `txStart` <= 0, `errTimeout` pulses 1 cycle, no `reqDone` pulses, and the state goes to IDLE.
  - The byte is dropped and `last` keeps the aborted index.
- Not defined: no counter is built, START waits indefinitely, and `errTimeout` is tied 0.

## Test plan
- Single request: reset, `arbEn`=1, `reqValid`=4'b0001, byte 0 = 8'h7A. Required:
  - `reqReady` = 0001 for 1 cycle.
  - `txStart` falls 1 cycle after `txBusy` rises.
  - Looped-back Uart8 rx gives `rxOut` = 8'h7A.
  - `reqDone` = 0001 once; `arbBusy` back to 0.
- All four requesters valid at once, bytes 8'hA0..8'hA3. Required:
  - Grant order 0,1,2,3.
  - Looped-back rx stream A0,A1,A2,A3.
  - Exactly 4 `reqReady` and 4 `reqDone` pulses.
- Fairness: requester 1 continuously valid, requester 3 raises valid during frame 1. Required: the next grant is 3, then 1.
- `arbEn` dropped mid-frame (byte 8'hB1). Required:
  - Frame completes and `reqDone` pulses.
  - `txEn` falls in the IDLE cycle.
  - Pending requests are not granted until `arbEn` returns.
- `rstN` low for 1 cycle during WAIT_DONE. Required:
  - Next cycle all outputs are 0 and state is IDLE.
  - No `reqDone` pulse.
  - Following request 8'h31 transmits correctly.
- With `UART_ARB_TIMEOUT_EN` and `START_TIMEOUT`=64, `txBusy` forced 0. Required:
  - `errTimeout` pulses 65 cycles after grant.
  - `txStart` = 0 and `reqDone` stays 0.
  - Without the macro, `arbBusy` stays 1.
